// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: word stores, fixed-latency loads, sticky error flag
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  proc2Dmem_command,
    input  logic [31:0] proc2Dmem_addr,
    input  logic [31:0] proc2mem_data,
    output logic [31:0] mem2proc_data,
    output logic        mem2proc_valid,
    output logic        mem2proc_err,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] CMD_LOAD  = 2'b01;
    localparam logic [1:0] CMD_STORE = 2'b10;
    localparam logic [1:0] CMD_RSVD  = 2'b11;
    // The output stage is excluded so busy drops while the last response is presented.
    localparam logic [LATENCY-1:0] BUSY_MASK = ~(LATENCY'(1) << (LATENCY - 1));

    logic [31:0]        mem [DEPTH];
    logic [AW-1:0]      idx;
    logic               in_range;
    logic               misaligned;
    logic               is_load;
    logic               is_store;
    logic               is_rsvd;
    logic               bad_cmd;
    logic [31:0]        rd_data;
    logic [LATENCY-1:0] pipe_valid;
    logic [31:0]        pipe_data [LATENCY];
    logic               err_q;

    assign idx        = proc2Dmem_addr[AW+1:2];
    assign in_range   = (proc2Dmem_addr[31:AW+2] == '0);
    assign misaligned = |proc2Dmem_addr[1:0];
    assign is_load    = (proc2Dmem_command == CMD_LOAD);
    assign is_store   = (proc2Dmem_command == CMD_STORE);
    assign is_rsvd   = (proc2Dmem_command == CMD_RSVD);
    assign bad_cmd    = is_rsvd | ((is_load | is_store) & (misaligned | ~in_range));

    // Non-load cycles push zero data so the output reads 0 whenever valid is low.
    assign rd_data = (is_load && in_range) ? mem[idx] : 32'h0;

    // Array is deliberately outside the reset domain: contents survive reset.
    always_ff @(posedge clk) begin
        if (is_store && in_range) begin
            mem[idx] <= proc2mem_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_data[i] <= 32'h0;
            end
            err_q <= 1'b0;
        end else begin
            pipe_valid[0] <= is_load;
            pipe_data[0]  <= rd_data;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
            if (bad_cmd) begin
                err_q <= 1'b1;
            end
        end
    end

    assign mem2proc_valid = pipe_valid[LATENCY-1];
    assign mem2proc_data  = pipe_data[LATENCY-1];
    assign mem2proc_err   = err_q;
    assign busy           = |(pipe_valid & BUSY_MASK);
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed and random checks of dmem_responder at LATENCY 1 and 4
module tb_dmem_responder;
    localparam int DEPTH = 16;
    localparam int NTAB  = 2048;
    localparam logic [1:0] C_NONE  = 2'b00;
    localparam logic [1:0] C_LOAD  = 2'b01;
    localparam logic [1:0] C_STORE = 2'b10;
    localparam logic [1:0] C_RSVD  = 2'b11;

    logic        clk;
    logic        rst;
    logic [1:0]  command;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic [31:0] data1, data4;
    logic        valid1, valid4;
    logic        err1, err4;
    logic        busy1, busy4;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst),
        .proc2Dmem_command(command), .proc2Dmem_addr(addr), .proc2mem_data(wdata),
        .mem2proc_data(data1), .mem2proc_valid(valid1), .mem2proc_err(err1), .busy(busy1)
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst),
        .proc2Dmem_command(command), .proc2Dmem_addr(addr), .proc2mem_data(wdata),
        .mem2proc_data(data4), .mem2proc_valid(valid4), .mem2proc_err(err4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec;
    int          n_err;
    int          cyc;
    bit          exp_err;
    // Expected outputs indexed by the clock edge after which they are visible.
    bit          ev1 [NTAB];
    bit          ev4 [NTAB];
    bit          eb4 [NTAB];
    logic [31:0] ed1 [NTAB];
    logic [31:0] ed4 [NTAB];
    logic [31:0] model [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h edge=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_cycle();
        chk("l1_valid", {31'h0, valid1}, {31'h0, ev1[cyc]});
        chk("l1_data",  data1, ed1[cyc]);
        chk("l1_busy",  {31'h0, busy1}, 32'h0);
        chk("l1_err",   {31'h0, err1}, {31'h0, exp_err});
        chk("l4_valid", {31'h0, valid4}, {31'h0, ev4[cyc]});
        chk("l4_data",  data4, ed4[cyc]);
        chk("l4_busy",  {31'h0, busy4}, {31'h0, eb4[cyc]});
        chk("l4_err",   {31'h0, err4}, {31'h0, exp_err});
    endtask

    task automatic check_reset_outputs();
        chk("rst_l1_valid", {31'h0, valid1}, 32'h0);
        chk("rst_l1_data",  data1, 32'h0);
        chk("rst_l1_err",   {31'h0, err1}, 32'h0);
        chk("rst_l4_valid", {31'h0, valid4}, 32'h0);
        chk("rst_l4_data",  data4, 32'h0);
        chk("rst_l4_busy",  {31'h0, busy4}, 32'h0);
        chk("rst_l4_err",   {31'h0, err4}, 32'h0);
    endtask

    // Drive one command at the negedge, let it be accepted, then check at the next negedge.
    task automatic issue(input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input bit sets_err);
        command = cmd;
        addr    = a;
        wdata   = wd;
        @(posedge clk);
        cyc++;
        if (cmd == C_LOAD) begin
            ev1[cyc]     = 1'b1;
            ed1[cyc]     = rd;
            ev4[cyc+3]   = 1'b1;
            ed4[cyc+3]   = rd;
            eb4[cyc]     = 1'b1;
            eb4[cyc+1]   = 1'b1;
            eb4[cyc+2]   = 1'b1;
        end
        if (sets_err) exp_err = 1'b1;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(C_NONE, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        #1;
        check_reset_outputs();
        for (int i = cyc + 1; i < NTAB; i++) begin
            ev1[i] = 1'b0; ev4[i] = 1'b0; eb4[i] = 1'b0;
            ed1[i] = 32'h0; ed4[i] = 32'h0;
        end
        exp_err = 1'b0;
        idle(n);
        rst = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc = 0;
        exp_err = 1'b0;
        for (int i = 0; i < NTAB; i++) begin
            ed1[i] = 32'h0;
            ed4[i] = 32'h0;
        end
        rst = 1'b0;
        command = C_NONE;
        addr = 32'h0;
        wdata = 32'h0;
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b1;

        // Store then immediate load of the same word.
        issue(C_STORE, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        issue(C_LOAD,  32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        idle(4);

        // Back-to-back stores then back-to-back loads.
        issue(C_STORE, 32'h0, 32'd1, 32'h0, 1'b0);
        issue(C_STORE, 32'h4, 32'd2, 32'h0, 1'b0);
        issue(C_STORE, 32'h8, 32'd3, 32'h0, 1'b0);
        issue(C_STORE, 32'hC, 32'd4, 32'h0, 1'b0);
        issue(C_LOAD,  32'h0, 32'h0, 32'd1, 1'b0);
        issue(C_LOAD,  32'h4, 32'h0, 32'd2, 1'b0);
        issue(C_LOAD,  32'h8, 32'h0, 32'd3, 1'b0);
        issue(C_LOAD,  32'hC, 32'h0, 32'd4, 1'b0);
        idle(5);

        // Out-of-range accesses.
        issue(C_LOAD,  32'h40, 32'h0, 32'h0, 1'b1);
        issue(C_LOAD,  32'h8000_0000, 32'h0, 32'h0, 1'b1);
        issue(C_STORE, 32'h44, 32'hBAD0BAD0, 32'h0, 1'b1);
        issue(C_LOAD,  32'h0, 32'h0, 32'd1, 1'b0);
        issue(C_LOAD,  32'h4, 32'h0, 32'd2, 1'b0);
        idle(5);

        // Reset with a load in flight: the LATENCY=4 response must never appear.
        issue(C_LOAD, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        do_reset(3);
        idle(5);
        issue(C_LOAD, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        idle(4);

        // Misaligned load returns the word and sets err.
        issue(C_STORE, 32'h0, 32'hA5A5A5A5, 32'h0, 1'b0);
        issue(C_LOAD,  32'h2, 32'h0, 32'hA5A5A5A5, 1'b1);
        idle(5);

        // Reserved command: no response, err set.
        do_reset(2);
        issue(C_RSVD, 32'h0, 32'h0, 32'h0, 1'b1);
        idle(5);

        // Random aligned traffic against a memory model.
        do_reset(2);
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = $urandom;
            issue(C_STORE, 32'(i) << 2, model[i], 32'h0, 1'b0);
        end
        for (int i = 0; i < 200; i++) begin
            logic [1:0]  c;
            int          w;
            logic [31:0] d;
            c = 2'($urandom_range(0, 2));
            w = int'($urandom_range(0, DEPTH - 1));
            d = $urandom;
            if (c == C_STORE) begin
                issue(C_STORE, 32'(w) << 2, d, 32'h0, 1'b0);
                model[w] = d;
            end else if (c == C_LOAD) begin
                issue(C_LOAD, 32'(w) << 2, 32'h0, model[w], 1'b0);
            end else begin
                issue(C_NONE, 32'(w) << 2, d, 32'h0, 1'b0);
            end
        end
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
